// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the run-control state encoding, the per-program base addresses,
// the reserved program-select code and the default counter widths.
package pc_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int unsigned PROG_BASE [3] = '{0, 200, 400};

    // This select code has no program behind it; a start with it ends at once with a fault.
    localparam logic [1:0] PROG_SEL_INVALID = 2'd3;

    function automatic int unsigned prog_base(input logic [1:0] sel);
        case (sel)
            2'd1:    return PROG_BASE[1];
            2'd2:    return PROG_BASE[2];
            default: return PROG_BASE[0];
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_clear   load zero (takes priority over i_enable)
//   i_enable  count up by one, holding at all-ones
//   o_count   current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and run-control block for the correction-decoder core.
// Ports:
//   i_clk, i_reset         clock, asynchronous active-low reset
//   i_start, i_prog_sel    run request and program select (taken together)
//   i_halt                 current instruction is HALT
//   i_branch, i_address    branch decision and absolute target
//   i_stall                freeze pc this cycle
//   o_pc, o_fetch_en       fetch address and instruction-memory read enable
//   o_busy, o_done         running / finished (level)
//   o_fault                abnormal end, valid while o_done
//   o_cycle_count          edges spent in RUN (saturating)
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RUN   | fetching; pc advances, branches or holds
// DONE  | finished; pc and cycle count held for readout until next start
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_prog_sel,
    input  logic             i_halt,
    input  logic             i_branch,
    input  logic [PC_W-1:0]  i_address,
    input  logic             i_stall,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_fetch_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_cycle_count
);

    pc_state_t       r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_fault;

    pc_state_t       w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_fault_nxt;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic [PC_W-1:0] w_base;

    assign w_base = PC_W'(prog_base(i_prog_sel));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        w_cnt_clr   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_cnt_clr = 1'b1;
                    if (i_prog_sel == PROG_SEL_INVALID) begin
                        w_state_nxt = DONE;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                        w_pc_nxt    = w_base;
                        w_fault_nxt = 1'b0;
                    end
                end
            end
            RUN: begin
                // Stall masks halt and branch entirely; they are re-seen next cycle.
                if (!i_stall) begin
                    if (i_halt) begin
                        w_state_nxt = DONE;
                        w_fault_nxt = 1'b0;
                    end else if (i_branch) begin
                        w_pc_nxt = i_address;
                    end else if (r_pc == {PC_W{1'b1}}) begin
                        // Running off the end of program space: stop rather than wrap.
                        w_state_nxt = DONE;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Every RUN edge counts, stalled ones and the exit edge included.
    assign w_cnt_en = (r_state == RUN);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_reset),
        .i_clear  (w_cnt_clr),
        .i_enable (w_cnt_en),
        .o_count  (o_cycle_count)
    );

    assign o_pc       = r_pc;
    assign o_busy     = (r_state == RUN);
    assign o_done     = (r_state == DONE);
    assign o_fault    = r_fault;
    assign o_fetch_en = (r_state == RUN) && !i_stall;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int PC_W = 10;

    logic            clk;
    logic            reset;
    logic            start;
    logic [1:0]      prog_sel;
    logic            halt;
    logic            branch;
    logic [PC_W-1:0] address;
    logic            stall;

    logic [PC_W-1:0] pc, pc_s;
    logic            fetch_en, fetch_en_s;
    logic            busy, busy_s;
    logic            done, done_s;
    logic            fault, fault_s;
    logic [15:0]     cycle_count;
    logic [3:0]      cycle_count_s;

    int n_assert = 0;
    int n_fail   = 0;

    pc_sequencer #(.PC_W(PC_W), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_prog_sel(prog_sel),
        .i_halt(halt), .i_branch(branch), .i_address(address), .i_stall(stall),
        .o_pc(pc), .o_fetch_en(fetch_en), .o_busy(busy), .o_done(done),
        .o_fault(fault), .o_cycle_count(cycle_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    pc_sequencer #(.PC_W(PC_W), .CNT_W(4)) dut_s (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_prog_sel(prog_sel),
        .i_halt(halt), .i_branch(branch), .i_address(address), .i_stall(stall),
        .o_pc(pc_s), .o_fetch_en(fetch_en_s), .o_busy(busy_s), .o_done(done_s),
        .o_fault(fault_s), .o_cycle_count(cycle_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; prog_sel = 2'd0; halt = 1'b0;
        branch = 1'b0; address = '0; stall = 1'b0;
        #2;
        check("rst_pc", 32'(pc), 0);
        check("rst_cnt", 32'(cycle_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_fetch", 32'(fetch_en), 0);
        #10 reset = 1'b1;

        // start program 1
        start = 1'b1; prog_sel = 2'd1;
        tick();
        start = 1'b0;
        check("start_pc", 32'(pc), 200);
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_cnt", 32'(cycle_count), 0);
        check("start_fetch", 32'(fetch_en), 1);
        ticks(3);
        check("seq_pc", 32'(pc), 203);
        check("seq_cnt", 32'(cycle_count), 3);
        ticks(2);
        check("seq_pc205", 32'(pc), 205);

        // branch
        branch = 1'b1; address = 10'd16;
        tick();
        check("br_pc", 32'(pc), 16);
        check("br_cnt", 32'(cycle_count), 6);
        address = 10'd205;
        tick();
        check("br_back", 32'(pc), 205);

        // halt beats branch
        halt = 1'b1; branch = 1'b1; address = 10'd16;
        tick();
        halt = 1'b0; branch = 1'b0;
        check("halt_done", 32'(done), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_pc", 32'(pc), 205);
        check("halt_fault", 32'(fault), 0);
        check("halt_cnt", 32'(cycle_count), 8);
        tick();
        check("done_pc_hold", 32'(pc), 205);
        check("done_cnt_hold", 32'(cycle_count), 8);
        check("done_fetch", 32'(fetch_en), 0);
        check("done_level", 32'(done), 1);

        // restart from DONE with program 0
        start = 1'b1; prog_sel = 2'd0;
        tick();
        start = 1'b0;
        check("rs_pc", 32'(pc), 0);
        check("rs_busy", 32'(busy), 1);
        check("rs_done", 32'(done), 0);
        check("rs_cnt", 32'(cycle_count), 0);
        branch = 1'b1; address = 10'd10;
        tick();
        branch = 1'b0;
        check("rs_br10", 32'(pc), 10);

        // stall with halt held: both ignored
        stall = 1'b1; halt = 1'b1;
        #1;
        check("stall_fetch", 32'(fetch_en), 0);
        ticks(4);
        check("stall_pc", 32'(pc), 10);
        check("stall_busy", 32'(busy), 1);
        check("stall_cnt", 32'(cycle_count), 5);
        stall = 1'b0; halt = 1'b0;
        #1;
        check("unstall_fetch", 32'(fetch_en), 1);
        tick();
        check("unstall_pc", 32'(pc), 11);

        // start during RUN ignored
        start = 1'b1; prog_sel = 2'd2;
        tick();
        start = 1'b0;
        check("runstart_pc", 32'(pc), 12);
        check("runstart_cnt", 32'(cycle_count), 7);

        // run off the end of program space
        branch = 1'b1; address = 10'd1022;
        tick();
        branch = 1'b0;
        check("ovf_1022", 32'(pc), 1022);
        tick();
        check("ovf_1023", 32'(pc), 1023);
        check("ovf_busy", 32'(busy), 1);
        tick();
        check("ovf_done", 32'(done), 1);
        check("ovf_fault", 32'(fault), 1);
        check("ovf_pc", 32'(pc), 1023);
        check("ovf_cnt", 32'(cycle_count), 10);

        // saturation on the narrow counter
        start = 1'b1; prog_sel = 2'd2;
        tick();
        start = 1'b0;
        check("sat_start_pc", 32'(pc), 400);
        check("sat_start_fault", 32'(fault), 0);
        check("sat_start_cnt_s", 32'(cycle_count_s), 0);
        ticks(20);
        check("sat_pc", 32'(pc), 420);
        check("sat_cnt_wide", 32'(cycle_count), 20);
        check("sat_cnt_narrow", 32'(cycle_count_s), 15);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("sat_halt_done", 32'(done_s), 1);
        check("sat_halt_cnt_s", 32'(cycle_count_s), 15);
        check("sat_halt_cnt", 32'(cycle_count), 21);
        start = 1'b1; prog_sel = 2'd1;
        tick();
        start = 1'b0;
        check("sat_clr_cnt_s", 32'(cycle_count_s), 0);
        check("sat_clr_pc_s", 32'(pc_s), 200);
        check("sat_clr_busy_s", 32'(busy_s), 1);
        tick();
        check("mid_pc", 32'(pc), 201);

        // asynchronous reset mid-cycle
        #3 reset = 1'b0;
        #1;
        check("ar_pc", 32'(pc), 0);
        check("ar_cnt", 32'(cycle_count), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(done), 0);
        check("ar_fault", 32'(fault), 0);
        check("ar_fetch", 32'(fetch_en), 0);
        check("ar_cnt_s", 32'(cycle_count_s), 0);
        #1 reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_pc", 32'(pc), 0);

        // invalid program select from IDLE
        start = 1'b1; prog_sel = 2'd3;
        tick();
        start = 1'b0;
        check("inv_done", 32'(done), 1);
        check("inv_fault", 32'(fault), 1);
        check("inv_busy", 32'(busy), 0);
        check("inv_pc", 32'(pc), 0);
        check("inv_cnt", 32'(cycle_count), 0);
        tick();
        check("inv_hold", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
